// File: rtl/dc_sched_pkg.sv
// Shared types, widths and the saturation helper for the multi-channel DC-blocking scheduler.
package dc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int SAMPLE_W = 16;
  localparam int ACC_W    = 18;

  localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 16'sh8000;

  function automatic logic signed [SAMPLE_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
    logic signed [SAMPLE_W-1:0] r;
    if (v > 18'sd32767) begin
      r = SAT_MAX;
    end else if (v < -18'sd32768) begin
      r = SAT_MIN;
    end else begin
      r = v[SAMPLE_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/dc_block_alu.sv
// Shared one-pole DC-blocker datapath: y = sat(x - x1 + y1 - (y1 >>> K_SHIFT)).
module dc_block_alu
  import dc_sched_pkg::*;
#(
  parameter int K_SHIFT = 7
) (
  input  logic signed [SAMPLE_W-1:0] x,
  input  logic signed [SAMPLE_W-1:0] x1,
  input  logic signed [SAMPLE_W-1:0] y1,
  output logic signed [SAMPLE_W-1:0] y
);

  logic signed [ACC_W-1:0] x_s;
  logic signed [ACC_W-1:0] x1_s;
  logic signed [ACC_W-1:0] y1_s;
  logic signed [ACC_W-1:0] full_s;

  assign x_s    = {{(ACC_W-SAMPLE_W){x[SAMPLE_W-1]}}, x};
  assign x1_s   = {{(ACC_W-SAMPLE_W){x1[SAMPLE_W-1]}}, x1};
  assign y1_s   = {{(ACC_W-SAMPLE_W){y1[SAMPLE_W-1]}}, y1};
  // 18 bits hold the worst case (|full| <= 98047) without wrapping.
  assign full_s = x_s - x1_s + (y1_s - (y1_s >>> K_SHIFT));
  assign y      = saturate(full_s);

endmodule

// File: rtl/dc_block_scheduler.sv
// Time-multiplexed DC blocker: snapshot all channels on a trigger, filter one channel
// per cycle through a shared ALU, then publish every output together.
module dc_block_scheduler
  import dc_sched_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int K_SHIFT = 7
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         audio_trigger,
  input  logic [NUM_CH*SAMPLE_W-1:0]   signal_in,
  input  logic [NUM_CH-1:0]            ch_enable,
  input  logic                         overrun_clr,
  output logic [NUM_CH*SAMPLE_W-1:0]   signal_out,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         overrun
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  state_t                      state_r;
  state_t                      next_state_s;
  logic [IDX_W-1:0]            ch_idx_r;
  logic signed [SAMPLE_W-1:0]  snap_x_r [NUM_CH];
  logic [NUM_CH-1:0]           snap_en_r;
  logic signed [SAMPLE_W-1:0]  x1_r     [NUM_CH];
  logic signed [SAMPLE_W-1:0]  y1_r     [NUM_CH];
  logic signed [SAMPLE_W-1:0]  stage_r  [NUM_CH];
  logic signed [SAMPLE_W-1:0]  alu_y_s;
  logic                        drop_s;

  dc_block_alu #(.K_SHIFT(K_SHIFT)) u_alu (
    .x  (snap_x_r[ch_idx_r]),
    .x1 (x1_r[ch_idx_r]),
    .y1 (y1_r[ch_idx_r]),
    .y  (alu_y_s)
  );

  // Next-state logic; a trigger arriving while a pass is in flight is dropped.
  always_comb begin
    next_state_s = state_r;
    drop_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (audio_trigger) begin
          next_state_s = RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        drop_s = audio_trigger;
        if (ch_idx_r == LAST_IDX) begin
          next_state_s = COMMIT;
        end else begin
          next_state_s = RUN;
        end
      end
      COMMIT: begin
        drop_s       = audio_trigger;
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State, snapshot, per-channel history, staging and output registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r    <= IDLE;
      ch_idx_r   <= '0;
      snap_en_r  <= '0;
      signal_out <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        snap_x_r[c] <= 16'sd0;
        x1_r[c]     <= 16'sd0;
        y1_r[c]     <= 16'sd0;
        stage_r[c]  <= 16'sd0;
      end
    end else begin
      state_r   <= next_state_s;
      busy      <= (next_state_s != IDLE);
      out_valid <= 1'b0;
      if (drop_s) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (audio_trigger) begin
            ch_idx_r  <= '0;
            snap_en_r <= ch_enable;
            for (int c = 0; c < NUM_CH; c++) begin
              snap_x_r[c] <= signal_in[c*SAMPLE_W +: SAMPLE_W];
            end
          end
        end
        RUN: begin
          // A disabled channel also wipes its history so re-enable starts clean.
          if (snap_en_r[ch_idx_r]) begin
            stage_r[ch_idx_r] <= alu_y_s;
            x1_r[ch_idx_r]    <= snap_x_r[ch_idx_r];
            y1_r[ch_idx_r]    <= alu_y_s;
          end else begin
            stage_r[ch_idx_r] <= 16'sd0;
            x1_r[ch_idx_r]    <= 16'sd0;
            y1_r[ch_idx_r]    <= 16'sd0;
          end
          if (ch_idx_r != LAST_IDX) begin
            ch_idx_r <= ch_idx_r + IDX_W'(1);
          end
        end
        COMMIT: begin
          out_valid <= 1'b1;
          for (int c = 0; c < NUM_CH; c++) begin
            signal_out[c*SAMPLE_W +: SAMPLE_W] <= stage_r[c];
          end
        end
        default: begin
          ch_idx_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dc_block_scheduler.sv
// Directed self-checking bench for dc_block_scheduler (NUM_CH=4, K_SHIFT=7).
module tb_dc_block_scheduler;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        audio_trigger;
  logic [63:0] signal_in;
  logic [3:0]  ch_enable;
  logic        overrun_clr;
  logic [63:0] signal_out;
  logic        out_valid;
  logic        busy;
  logic        overrun;

  int total = 0;
  int bad   = 0;

  dc_block_scheduler #(.NUM_CH(4), .K_SHIFT(7)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .audio_trigger (audio_trigger),
    .signal_in     (signal_in),
    .ch_enable     (ch_enable),
    .overrun_clr   (overrun_clr),
    .signal_out    (signal_out),
    .out_valid     (out_valid),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk_val(input string tag, input int obs, input int exp_v);
    total++;
    if (obs != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic signed [15:0] ch_out(input int c);
    return signal_out[c*16 +: 16];
  endfunction

  task automatic set_in(input int c, input int v);
    signal_in[c*16 +: 16] = 16'(v);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Trigger one pass, measure latency and busy span, then check all four outputs.
  task automatic run_pass(input string tag, input int e0, input int e1, input int e2, input int e3);
    int n;
    int busy_cnt;
    n = 0;
    busy_cnt = 0;
    audio_trigger = 1'b1;
    tick();
    audio_trigger = 1'b0;
    while (!out_valid && n < 20) begin
      if (busy) busy_cnt++;
      tick();
      n++;
    end
    chk_val({tag, "_latency"}, n, 5);
    chk_val({tag, "_busy_cycles"}, busy_cnt, 5);
    chk_val({tag, "_ch0"}, ch_out(0), e0);
    chk_val({tag, "_ch1"}, ch_out(1), e1);
    chk_val({tag, "_ch2"}, ch_out(2), e2);
    chk_val({tag, "_ch3"}, ch_out(3), e3);
    tick();
    chk_val({tag, "_valid_one_cycle"}, int'(out_valid), 0);
  endtask

  initial begin
    int vcnt;
    rst_in        = 1'b1;
    audio_trigger = 1'b0;
    signal_in     = 64'd0;
    ch_enable     = 4'b0000;
    overrun_clr   = 1'b0;
    tick();
    tick();
    rst_in = 1'b0;
    tick();
    chk_val("rst_out", int'(signal_out != 64'd0), 0);
    chk_val("rst_busy", int'(busy), 0);
    chk_val("rst_overrun", int'(overrun), 0);

    // ch0 step, ch1 negative full scale, ch2 disabled, ch3 small negative
    set_in(0, 1000); set_in(1, -32768); set_in(2, 500); set_in(3, -200);
    ch_enable = 4'b1011;
    run_pass("p1", 1000, -32768, 0, -200);
    set_in(1, 32767);
    run_pass("p2", 993, 32767, 0, -198);
    ch_enable = 4'b1111;
    run_pass("p3", 986, 32512, 500, -196);

    // Overrun: second trigger two edges in, with a simultaneous clear (set wins)
    audio_trigger = 1'b1;
    tick();
    audio_trigger = 1'b0;
    tick();
    audio_trigger = 1'b1;
    overrun_clr   = 1'b1;
    set_in(0, 0);
    tick();
    audio_trigger = 1'b0;
    overrun_clr   = 1'b0;
    chk_val("ovr_set_wins", int'(overrun), 1);
    vcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) vcnt++;
      tick();
    end
    chk_val("ovr_valid_count", vcnt, 1);
    chk_val("ovr_ch0_snapshot", ch_out(0), 979);
    chk_val("ovr_ch1", ch_out(1), 32258);
    chk_val("ovr_ch2", ch_out(2), 497);
    chk_val("ovr_ch3", ch_out(3), -194);
    chk_val("ovr_sticky", int'(overrun), 1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk_val("ovr_cleared", int'(overrun), 0);

    // Reset mid-RUN at ch_idx==2, with overrun set beforehand
    set_in(0, 1234);
    audio_trigger = 1'b1;
    tick();
    tick();
    audio_trigger = 1'b0;
    tick();
    chk_val("mid_pre_overrun", int'(overrun), 1);
    rst_in = 1'b1;
    #1;
    chk_val("mid_rst_out", int'(signal_out != 64'd0), 0);
    chk_val("mid_rst_valid", int'(out_valid), 0);
    chk_val("mid_rst_busy", int'(busy), 0);
    chk_val("mid_rst_overrun", int'(overrun), 0);
    tick();
    rst_in = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) vcnt++;
      tick();
    end
    chk_val("mid_no_valid", vcnt, 0);
    run_pass("post", 1234, 32767, 500, -200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
